// File: rtl/dht_responder.sv
// rtl/dht_responder.sv - DHT11-class sensor emulator on an open-drain single-wire line
//
// Purpose: waits for a host start pulse on onewire, answers with the sensor
// acknowledge (gap, 80 us low, 80 us high), then sends hum, humd, tem, temd
// and their 8-bit sum, MSB first, as 50 us low + 26/70 us high pulses.
//
// Ports:
//   clk        in     system clock
//   reset      in     asynchronous active-high reset
//   onewire    inout  open-drain line, only ever driven 0 or released
//   enable     in     arms start detection while high
//   hum..temd  in     measurement bytes, captured when a start is accepted
//   busy       out    high from start acceptance until the line is released after END_LOW
//   frame_done out    one-cycle pulse when a frame completes
module dht_responder #(
    parameter int CLKS_PER_US   = 50,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        onewire,
    input  logic       enable,
    input  logic [7:0] hum,
    input  logic [7:0] humd,
    input  logic [7:0] tem,
    input  logic [7:0] temd,
    output logic       busy,
    output logic       frame_done
);

    localparam int START_CYC = START_MIN_US * CLKS_PER_US;
    localparam int WAIT_CYC  = RESP_DELAY_US * CLKS_PER_US;
    localparam int RESP_CYC  = 80 * CLKS_PER_US;
    localparam int MAX_CYC   = (START_CYC > RESP_CYC)
                             ? ((START_CYC > WAIT_CYC) ? START_CYC : WAIT_CYC)
                             : ((RESP_CYC > WAIT_CYC) ? RESP_CYC : WAIT_CYC);
    localparam int CNT_W     = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] LEN_START = CNT_W'(START_CYC);
    localparam logic [CNT_W-1:0] LEN_WAIT  = CNT_W'(WAIT_CYC);
    localparam logic [CNT_W-1:0] LEN_RESP  = CNT_W'(RESP_CYC);
    localparam logic [CNT_W-1:0] LEN_LOW   = CNT_W'(50 * CLKS_PER_US);
    localparam logic [CNT_W-1:0] LEN_ONE   = CNT_W'(70 * CLKS_PER_US);
    localparam logic [CNT_W-1:0] LEN_ZERO  = CNT_W'(26 * CLKS_PER_US);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST_LOW,
        S_WAIT_RESP,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_END_LOW
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [5:0]       bit_idx_q;
    logic [39:0]      shift_q;
    logic             drive_low_q;
    logic             busy_q;
    logic             done_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             line_s;
    logic [7:0]       checksum;
    logic [CNT_W-1:0] phase_len;
    logic             phase_last;

    // Released line idles high, so the synchronizer resets to 1 to avoid a
    // phantom start right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= onewire;
            sync2_q <= sync1_q;
        end
    end

    assign line_s   = sync2_q;
    assign checksum = hum + humd + tem + temd;

    // Length of the current timed phase; the bit-high width follows the MSB
    // of the shift register, which always holds the bit being sent.
    always_comb begin
        phase_len = LEN_RESP;
        case (state_q)
            S_WAIT_RESP:             phase_len = LEN_WAIT;
            S_RESP_LOW, S_RESP_HIGH: phase_len = LEN_RESP;
            S_BIT_LOW, S_END_LOW:    phase_len = LEN_LOW;
            S_BIT_HIGH:              phase_len = shift_q[39] ? LEN_ONE : LEN_ZERO;
            default:                 phase_len = LEN_RESP;
        endcase
    end

    assign phase_last = (cnt_q == phase_len - 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            drive_low_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!line_s && enable) begin
                        state_q <= S_HOST_LOW;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                S_HOST_LOW: begin
                    if (!line_s) begin
                        if (cnt_q != LEN_START) cnt_q <= cnt_q + 1'b1;
                    end else if (cnt_q == LEN_START) begin
                        shift_q <= {hum, humd, tem, temd, checksum};
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_WAIT_RESP;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    if (!phase_last) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                        case (state_q)
                            S_WAIT_RESP: begin
                                drive_low_q <= 1'b1;
                                state_q     <= S_RESP_LOW;
                            end
                            S_RESP_LOW: begin
                                drive_low_q <= 1'b0;
                                bit_idx_q   <= '0;
                                state_q     <= S_RESP_HIGH;
                            end
                            S_RESP_HIGH, S_BIT_LOW: begin
                                drive_low_q <= (state_q == S_RESP_HIGH);
                                state_q     <= (state_q == S_RESP_HIGH) ? S_BIT_LOW : S_BIT_HIGH;
                            end
                            S_BIT_HIGH: begin
                                shift_q     <= {shift_q[38:0], 1'b0};
                                drive_low_q <= 1'b1;
                                if (bit_idx_q == 6'd39) begin
                                    state_q <= S_END_LOW;
                                end else begin
                                    bit_idx_q <= bit_idx_q + 1'b1;
                                    state_q   <= S_BIT_LOW;
                                end
                            end
                            default: begin
                                drive_low_q <= 1'b0;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                                state_q     <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign onewire    = drive_low_q ? 1'b0 : 1'bz;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_dht_responder.sv
// tb/tb_dht_responder.sv - self-checking bench for dht_responder
module tb_dht_responder;
    localparam int CPU       = 2;
    localparam int SMU       = 20;
    localparam int RDU       = 30;
    localparam int START_CYC = SMU * CPU;
    localparam int RUN_LIMIT = 1000;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       enable   = 1'b1;
    logic       host_low = 1'b0;
    logic [7:0] hum = '0, humd = '0, tem = '0, temd = '0;
    logic       busy, frame_done;
    wire        onewire;

    assign onewire = host_low ? 1'b0 : 1'bz;
    pullup (onewire);

    always #5 clk = ~clk;

    dht_responder #(
        .CLKS_PER_US  (CPU),
        .START_MIN_US (SMU),
        .RESP_DELAY_US(RDU)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .onewire   (onewire),
        .enable    (enable),
        .hum       (hum),
        .humd      (humd),
        .tem       (tem),
        .temd      (temd),
        .busy      (busy),
        .frame_done(frame_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a start is a run of at least START_CYC synced low
    // samples followed by a high one; an accepted start expands into the
    // full per-cycle drive pattern of the frame, consumed one entry per cycle.
    bit  exp_q[$];
    bit  m_drive = 1'b0;
    bit  m_done  = 1'b0;
    bit  m_s1    = 1'b1;
    bit  m_s2    = 1'b1;
    int  m_lowcnt = 0;

    function automatic void build_frame(input logic [7:0] a, b, c, d);
        logic [39:0] f;
        f = {a, b, c, d, 8'(a + b + c + d)};
        exp_q.delete();
        repeat (RDU * CPU) exp_q.push_back(1'b0);
        repeat (80 * CPU)  exp_q.push_back(1'b1);
        repeat (80 * CPU)  exp_q.push_back(1'b0);
        for (int i = 39; i >= 0; i--) begin
            repeat (50 * CPU) exp_q.push_back(1'b1);
            repeat ((f[i] ? 70 : 26) * CPU) exp_q.push_back(1'b0);
        end
        repeat (50 * CPU) exp_q.push_back(1'b1);
    endfunction

    always @(posedge clk) begin
        bit line_now;
        line_now = !(host_low || m_drive);
        if (reset) begin
            exp_q.delete();
            m_lowcnt = 0;
            m_s1 = 1'b1;
            m_s2 = 1'b1;
            m_drive = 1'b0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_done = 1'b1;
            end else if (m_lowcnt > 0) begin
                if (!m_s2) begin
                    if (m_lowcnt < START_CYC) m_lowcnt++;
                end else begin
                    if (m_lowcnt == START_CYC) build_frame(hum, humd, tem, temd);
                    m_lowcnt = 0;
                end
            end else if (!m_s2 && enable) begin
                m_lowcnt = 1;
            end
            m_drive = (exp_q.size() > 0) ? exp_q[0] : 1'b0;
            m_s2 = m_s1;
            m_s1 = line_now;
        end
    end

    bit cmp_en    = 1'b0;
    bit frame_win = 1'b0;
    int done_cnt  = 0;
    int busy_gap  = 0;

    always @(posedge clk) begin
        #1;
        if (frame_done) done_cnt++;
        if (frame_win && !busy) busy_gap++;
        if (cmp_en) begin
            check("line", onewire, !(host_low || m_drive));
            check("busy", busy, exp_q.size() > 0);
            check("frame_done", frame_done, m_done);
        end
    end

    task automatic host_pulse(input int n);
        @(negedge clk);
        host_low = 1'b1;
        repeat (n) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic run_len(input logic lvl, output int len);
        len = 0;
        while (onewire === lvl && len < RUN_LIMIT) begin
            len++;
            @(posedge clk);
            #1;
        end
        if (len >= RUN_LIMIT) check("run_timeout", len, 0);
    endtask

    // mode 0 plain, 1 change tem in bit 3 low, 2 host pull during RESP_HIGH, 3 reset in bit 5 low
    task automatic capture(input int mode, output logic [39:0] bits, output int gap,
                           output int rl, output int rh, output int max_hw, output bit aborted);
        int lw, hw, ew, d0;
        bits = '0; max_hw = 0; aborted = 1'b0; rh = 0;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        run_len(1'b1, gap);
        busy_gap = 0;
        frame_win = 1'b1;
        run_len(1'b0, rl);
        if (mode == 2) begin
            @(negedge clk);
            host_low = 1'b1;
            repeat (20) @(negedge clk);
            host_low = 1'b0;
            @(posedge clk);
            #1;
        end
        run_len(1'b1, rh);
        for (int i = 0; i < 40; i++) begin
            if (mode == 1 && i == 3) tem = 8'h20;
            if (mode == 3 && i == 5) begin
                @(negedge clk);
                reset = 1'b1;
                #1;
                check("reset_line_released", onewire, 1'b1);
                check("reset_busy", busy, 1'b0);
                check("reset_frame_done", frame_done, 1'b0);
                frame_win = 1'b0;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                aborted = 1'b1;
                return;
            end
            run_len(1'b0, lw);
            check("bit_low_w", lw, 50 * CPU);
            run_len(1'b1, hw);
            check("bit_high_w_legal", (hw == 26 * CPU) || (hw == 70 * CPU), 1'b1);
            bits[39 - i] = (hw > 48 * CPU);
            if (hw > max_hw) max_hw = hw;
        end
        frame_win = 1'b0;
        run_len(1'b0, ew);
        check("end_low_w", ew, 50 * CPU);
        check("frame_done_at_release", frame_done, 1'b1);
        check("busy_at_release", busy, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        check("frame_done_count", done_cnt - d0, 1);
        check("busy_gaps", busy_gap, 0);
    endtask

    task automatic full_frame(input logic [7:0] a, b, c, d, input int mode, input int hl,
                              output logic [39:0] bits, output int mhw);
        int gap, rl, rh;
        bit ab;
        hum = a; humd = b; tem = c; temd = d;
        host_pulse(hl);
        capture(mode, bits, gap, rl, rh, mhw, ab);
        check("resp_gap_incl_sync", gap, 2 + RDU * CPU);
        check("resp_low_w", rl, 80 * CPU);
        if (mode != 2 && !ab) check("resp_high_w", rh, 80 * CPU);
        if (!ab) begin
            check("byte_hum", bits[39:32], a);
            check("byte_humd", bits[31:24], b);
            check("byte_tem", bits[23:16], c);
            check("byte_temd", bits[15:8], d);
            check("byte_sum", bits[7:0], 8'(a + b + c + d));
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic expect_quiet(input string tag, input int cyc);
        int lows, busys;
        lows = 0; busys = 0;
        repeat (cyc) begin
            @(posedge clk);
            #1;
            if (onewire !== 1'b1) lows++;
            if (busy) busys++;
        end
        check({tag, "_no_pulldown"}, lows, 0);
        check({tag, "_no_busy"}, busys, 0);
    endtask

    initial begin
        logic [39:0] bits;
        int mhw, n;
        repeat (3) @(negedge clk);
        #1;
        check("rst_line", onewire, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        repeat (5) @(negedge clk);

        full_frame(8'h37, 8'h00, 8'h19, 8'h00, 0, START_CYC, bits, mhw);
        check("nominal_bytes", bits, 40'h3700190050);

        full_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, START_CYC, bits, mhw);
        check("wrap_sum", bits[7:0], 8'hFC);
        check("wrap_one_high_w", mhw, 140);

        host_pulse(START_CYC - 1);
        expect_quiet("short_start", 200);

        full_frame(8'h37, 8'h00, 8'h19, 8'h00, 1, START_CYC, bits, mhw);
        check("snapshot_tem", bits[23:16], 8'h19);
        tem = 8'h19;

        enable = 1'b0;
        host_pulse(START_CYC);
        expect_quiet("disabled", 200);
        enable = 1'b1;
        repeat (5) @(negedge clk);

        full_frame(8'h37, 8'h00, 8'h19, 8'h00, 2, START_CYC, bits, mhw);
        check("resp_high_pull_bytes", bits, 40'h3700190050);

        full_frame(8'h12, 8'h34, 8'h56, 8'h78, 3, START_CYC, bits, mhw);
        expect_quiet("after_reset", 20);

        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(START_CYC + 6, START_CYC - 4);
            if (n >= START_CYC) begin
                full_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                           0, n, bits, mhw);
            end else begin
                host_pulse(n);
                expect_quiet("rand_short", 100);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        failures++;
        $display("FAIL watchdog: time limit reached, got %0t expected completion", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog timeout");
    end

endmodule
